// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default configuration for the reset sequencer.
// RESET_SEQ_SOFT_RESET_EN adds the SOFT_HOLD state used by the software reset handshake.
package reset_seq_pkg;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    SYNC      = 3'd1,
    RELEASE   = 3'd2,
`ifdef RESET_SEQ_SOFT_RESET_EN
    DONE      = 3'd3,
    SOFT_HOLD = 3'd4
`else
    DONE      = 3'd3
`endif
  } seq_state_e;

endpackage

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert, synchronous-deassert reset chain; sync_out rises DEPTH edges after reset drops.
module reset_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  output logic sync_out
);

  logic [DEPTH-1:0] chain_r;

  // Shift ones in behind a released reset; any reset assertion empties the chain at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_r <= {DEPTH{1'b0}};
    end else begin
      chain_r <= {chain_r[DEPTH-2:0], 1'b1};
    end
  end

  assign sync_out = chain_r[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES active-low domain resets in ascending order, STAGE_DELAY cycles apart.
// Define RESET_SEQ_SOFT_RESET_EN to enable the soft_reset_req/soft_reset_ack handshake.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset_req,
  output logic                  soft_reset_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  all_ready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(STAGE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);

  seq_state_e            state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [NUM_STAGES-1:0] stage_r, stage_s;
  logic                  ack_r, ack_s;
  logic                  ready_r, busy_r;
  logic                  sync_done_s;
  logic                  interval_end_s;
  logic [NUM_STAGES-1:0] release_vec_s;

`ifndef RESET_SEQ_SOFT_RESET_EN
  logic unused_req_s;
  assign unused_req_s = soft_reset_req;
`endif

  reset_sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .sync_out (sync_done_s)
  );

  // Released bits form a contiguous run from bit 0, so adding one sets the next bit up.
  assign release_vec_s  = stage_r | (stage_r + NUM_STAGES'(1));
  assign interval_end_s = (cnt_r == CNT_LAST);

  // Next-state, counter and stage-release decisions.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    ack_s   = 1'b0;
    case (state_r)
      HOLD, SYNC: begin
        if (!sync_done_s) begin
          state_s = HOLD;
          cnt_s   = {CNT_W{1'b0}};
          stage_s = {NUM_STAGES{1'b0}};
        end else if (interval_end_s) begin
          state_s = RELEASE;
          cnt_s   = {CNT_W{1'b0}};
          stage_s = release_vec_s;
        end else begin
          state_s = SYNC;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (&stage_r) begin
          state_s = DONE;
        end else if (interval_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          stage_s = release_vec_s;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
`ifdef RESET_SEQ_SOFT_RESET_EN
        if (soft_reset_req) begin
          state_s = SOFT_HOLD;
          cnt_s   = {CNT_W{1'b0}};
          stage_s = {NUM_STAGES{1'b0}};
          ack_s   = 1'b1;
        end else begin
          state_s = DONE;
        end
`else
        state_s = DONE;
`endif
      end
`ifdef RESET_SEQ_SOFT_RESET_EN
      SOFT_HOLD: begin
        // Soft release skips the synchronizer: counting starts on the edge that drops ack.
        if (soft_reset_req) begin
          ack_s = 1'b1;
        end else begin
          state_s = RELEASE;
          cnt_s   = {CNT_W{1'b0}};
        end
      end
`endif
      default: begin
        state_s = HOLD;
        cnt_s   = {CNT_W{1'b0}};
        stage_s = {NUM_STAGES{1'b0}};
      end
    endcase
  end

  // State and registered outputs, all cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= HOLD;
      cnt_r   <= {CNT_W{1'b0}};
      stage_r <= {NUM_STAGES{1'b0}};
      ack_r   <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
      ack_r   <= ack_s;
      ready_r <= (state_s == DONE);
      busy_r  <= (state_s != DONE);
    end
  end

  assign stage_reset_n  = stage_r;
  assign soft_reset_ack = ack_r;
  assign all_ready      = ready_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected outputs are queued per edge number and compared when that edge is reached.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset_req;
  logic       soft_reset_ack;
  logic [2:0] stage_reset_n;
  logic       all_ready;
  logic       busy;

  logic       min_req = 1'b0;
  logic       min_ack;
  logic [0:0] min_stage;
  logic       min_ready;
  logic       min_busy;

  int check_count = 0;
  int pass_count  = 0;
  int edge_n;

  int         exp_edge_q[$];
  int         exp_unit_q[$];
  logic [5:0] exp_val_q[$];
  logic [5:0] obs_v;

  always #5 clock = ~clock;

  reset_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .soft_reset_req (soft_reset_req),
    .soft_reset_ack (soft_reset_ack),
    .stage_reset_n  (stage_reset_n),
    .all_ready      (all_ready),
    .busy           (busy)
  );

  reset_sequencer #(.NUM_STAGES(1), .STAGE_DELAY(1), .SYNC_STAGES(2)) dut_min (
    .clock          (clock),
    .reset          (reset),
    .soft_reset_req (min_req),
    .soft_reset_ack (min_ack),
    .stage_reset_n  (min_stage),
    .all_ready      (min_ready),
    .busy           (min_busy)
  );

  // Edge 1 is the first rising edge that samples reset low.
  always @(posedge clock or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic expect_at(input int e, input int unit, input logic [2:0] st,
                           input logic rdy, input logic bsy, input logic ack);
    exp_edge_q.push_back(e);
    exp_unit_q.push_back(unit);
    exp_val_q.push_back({st, rdy, bsy, ack});
  endtask

  task automatic flush_expect();
    exp_edge_q.delete();
    exp_unit_q.delete();
    exp_val_q.delete();
  endtask

  // Expected power-on release for both instances, edges counted from reset deassertion.
  task automatic push_power_on();
    expect_at(2,  1, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_at(3,  1, 3'b001, 1'b0, 1'b1, 1'b0);
    expect_at(4,  1, 3'b001, 1'b1, 1'b0, 1'b0);
    expect_at(17, 0, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_at(18, 0, 3'b001, 1'b0, 1'b1, 1'b0);
    expect_at(33, 0, 3'b001, 1'b0, 1'b1, 1'b0);
    expect_at(34, 0, 3'b011, 1'b0, 1'b1, 1'b0);
    expect_at(49, 0, 3'b011, 1'b0, 1'b1, 1'b0);
    expect_at(50, 0, 3'b111, 1'b0, 1'b1, 1'b0);
    expect_at(51, 0, 3'b111, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (edge_n < target && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check_val($sformatf("reach_edge_%0d", target), edge_n, target);
    #1;
  endtask

  // Pop and compare every expectation whose edge has just been reached.
  always @(negedge clock) begin
    for (int i = exp_edge_q.size() - 1; i >= 0; i--) begin
      if (exp_edge_q[i] <= edge_n) begin
        if (exp_unit_q[i] == 1) obs_v = {2'b00, min_stage, min_ready, min_busy, min_ack};
        else                    obs_v = {stage_reset_n, all_ready, busy, soft_reset_ack};
        check_val($sformatf("u%0d_e%0d_edge", exp_unit_q[i], exp_edge_q[i]), edge_n, exp_edge_q[i]);
        check_val($sformatf("u%0d_e%0d_stage", exp_unit_q[i], exp_edge_q[i]), obs_v[5:3], exp_val_q[i][5:3]);
        check_val($sformatf("u%0d_e%0d_rdy_busy_ack", exp_unit_q[i], exp_edge_q[i]), obs_v[2:0], exp_val_q[i][2:0]);
        exp_edge_q.delete(i);
        exp_unit_q.delete(i);
        exp_val_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    soft_reset_req = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_val("rst_stage", stage_reset_n, 3'b000);
    check_val("rst_ready", all_ready, 1'b0);
    check_val("rst_busy",  busy, 1'b1);
    check_val("rst_ack",   soft_reset_ack, 1'b0);
    check_val("rst_min_stage", min_stage, 1'b0);

    // Power-on sequence, aborted by a reset pulse between edges 30 and 31.
    #2 reset = 1'b0;
    push_power_on();
    run_to(30);
    check_val("pre_abort_stage", stage_reset_n, 3'b001);
    #1 reset = 1'b1;
    flush_expect();
    #1;
    check_val("abort_stage", stage_reset_n, 3'b000);
    check_val("abort_busy",  busy, 1'b1);
    check_val("abort_ready", all_ready, 1'b0);
    check_val("abort_min_stage", min_stage, 1'b0);
    #1 reset = 1'b0;

    // Full restart from the abort.
    push_power_on();
    expect_at(55, 0, 3'b111, 1'b1, 1'b0, 1'b0);
    expect_at(55, 1, 3'b001, 1'b1, 1'b0, 1'b0);
`ifdef RESET_SEQ_SOFT_RESET_EN
    expect_at(56,  0, 3'b000, 1'b0, 1'b1, 1'b1);
    expect_at(58,  0, 3'b000, 1'b0, 1'b1, 1'b1);
    expect_at(60,  0, 3'b000, 1'b0, 1'b1, 1'b1);
    expect_at(61,  0, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_at(76,  0, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_at(77,  0, 3'b001, 1'b0, 1'b1, 1'b0);
    expect_at(92,  0, 3'b001, 1'b0, 1'b1, 1'b0);
    expect_at(93,  0, 3'b011, 1'b0, 1'b1, 1'b0);
    expect_at(108, 0, 3'b011, 1'b0, 1'b1, 1'b0);
    expect_at(109, 0, 3'b111, 1'b0, 1'b1, 1'b0);
    expect_at(110, 0, 3'b111, 1'b1, 1'b0, 1'b0);
`else
    expect_at(56, 0, 3'b111, 1'b1, 1'b0, 1'b0);
    expect_at(60, 0, 3'b111, 1'b1, 1'b0, 1'b0);
    expect_at(62, 0, 3'b111, 1'b1, 1'b0, 1'b0);
`endif
    run_to(55);
    soft_reset_req = 1'b1;
    run_to(60);
    soft_reset_req = 1'b0;
`ifdef RESET_SEQ_SOFT_RESET_EN
    run_to(112);
`else
    run_to(62);
`endif
    check_val("phase_b_drained", exp_edge_q.size(), 0);

    // Request raised mid-sequence: ignored until DONE is reached.
    #1 reset = 1'b1;
    flush_expect();
    #1 reset = 1'b0;
    push_power_on();
    expect_at(20, 0, 3'b001, 1'b0, 1'b1, 1'b0);
`ifdef RESET_SEQ_SOFT_RESET_EN
    expect_at(52, 0, 3'b000, 1'b0, 1'b1, 1'b1);
    expect_at(54, 0, 3'b000, 1'b0, 1'b1, 1'b0);
`else
    expect_at(52, 0, 3'b111, 1'b1, 1'b0, 1'b0);
    expect_at(54, 0, 3'b111, 1'b1, 1'b0, 1'b0);
`endif
    run_to(19);
    soft_reset_req = 1'b1;
    run_to(53);
    soft_reset_req = 1'b0;
    run_to(56);
    check_val("phase_d_drained", exp_edge_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of sequenced reset domains; legal range 1..8.
REQ-002 Parameter STAGE_DELAY, default 16, clock cycles between consecutive domain releases; legal range 1..65535.
REQ-003 Parameter SYNC_STAGES, default 2, depth of the deassertion synchronizer; legal range 2..4.
REQ-004 clock  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset; assertion takes effect immediately, deassertion may be asynchronous to clock.
REQ-006 soft_reset_req  input  1  synchronous software reset request, level, four-phase.
REQ-007 soft_reset_ack  output  1  acknowledge for soft_reset_req.
REQ-008 stage_reset_n  output  NUM_STAGES  active-low per-domain resets; bit k feeds domain k.
REQ-009 all_ready  output  1  high when every domain is released.
REQ-010 busy  output  1  high whenever the block is not in DONE.

Function
REQ-011 FSM states: HOLD, SYNC, RELEASE, DONE, SOFT_HOLD; encoding is a package enum.
REQ-012 HOLD: all stage_reset_n=0; leaves to SYNC once the synchronized reset deasserts.
REQ-013 Edge 1 is defined as the first rising clock edge sampling reset low.
REQ-014 stage_reset_n[k] rises at edge SYNC_STAGES + (k+1)*STAGE_DELAY; defaults: 18, 34, 50.
REQ-015 Domains release strictly in ascending index order, one per STAGE_DELAY interval; a released bit never re-asserts except via reset or soft reset.
REQ-016 all_ready rises one edge after the last stage release (default edge 51), entering DONE; busy falls on the same edge.
REQ-017 Delay counter width is $clog2(STAGE_DELAY+1); it clears on every stage release and never wraps mid-interval.
REQ-018 In DONE with soft_reset_req=1: on the next edge all stage_reset_n=0, all_ready=0, soft_reset_ack=1, state=SOFT_HOLD.
REQ-019 SOFT_HOLD: ack holds 1 while req=1; the edge sampling req=0 drops ack, clears the counter and enters RELEASE.
REQ-020 Soft release: stage k rises (k+1)*STAGE_DELAY edges after the edge that dropped ack; no synchronizer delay applies.
REQ-021 soft_reset_req=1 in any state other than DONE or SOFT_HOLD is ignored and not acknowledged; if still high on reaching DONE, it is honoured on the following edge.
REQ-022 reset asserting in any state, including mid-release or in SOFT_HOLD, forces HOLD behaviour immediately and aborts the sequence.

Reset
REQ-023 While reset=1: stage_reset_n=all 0, all_ready=0, soft_reset_ack=0, busy=1, state=HOLD, counter=0, synchronizer chain=0.
REQ-024 Every flop in the block uses reset asynchronously; deassertion passes through the SYNC_STAGES chain before any output changes.

Configuration
REQ-025 Macro RESET_SEQ_SOFT_RESET_EN defined: REQ-018 to REQ-021 are implemented.
REQ-026 Macro undefined: soft_reset_req is present but ignored, soft_reset_ack is tied 0, and SOFT_HOLD is absent; all other behaviour is unchanged.

Structure
REQ-027 Package reset_seq_pkg holds the state enum and the default constants for NUM_STAGES, STAGE_DELAY and SYNC_STAGES.
REQ-028 Sub-module reset_sync_chain implements the SYNC_STAGES-deep asynchronous-assert, synchronous-deassert chain; it is instantiated once.

Verification
REQ-029 Defaults, reset deasserted -> stage_reset_n goes 000->001 at edge 18, 011 at 34, 111 at 50; all_ready=1 and busy=0 at edge 51.
REQ-030 reset pulsed high between edges 30 and 31 -> stage_reset_n=000 and busy=1 immediately; the sequence restarts from edge 1 after deassertion.
REQ-031 Macro on, DONE, req=1 for 5 cycles then 0 -> ack=1 the edge after req rises, outputs=000 during the request, ack=0 on the edge sampling req=0, stages released 16/32/48 edges later.
REQ-032 Macro on, req=1 asserted at edge 20 and held -> no ack before DONE; ack rises the edge after all_ready.
REQ-033 Macro off, req=1 in DONE -> ack stays 0 and stage_reset_n stays 111.
REQ-034 NUM_STAGES=1 and STAGE_DELAY=1 -> stage_reset_n[0] rises at edge 3 and all_ready at edge 4.
